// File: rtl/riscv_pkg.sv
// Shared RV64 pipeline types and constants for the instruction-fetch stage.
//   XLEN / ILEN   : address and instruction widths
//   NOP_INSTR     : addi x0,x0,0, used to fill an empty IF/ID slot
//   fetch_state_t : fetch FSM states
//   pc_sel_t      : next-PC mux select for fetch_pc_reg
//   ifid_t        : IF/ID pipeline register payload
package riscv_pkg;

   localparam int unsigned XLEN = 64;
   localparam int unsigned ILEN = 32;

   localparam logic [ILEN-1:0] NOP_INSTR = 32'h0000_0013;
   localparam logic [XLEN-1:0] PC_STEP   = 64'd4;

   typedef enum logic {
      RUN  = 1'b0,
      HALT = 1'b1
   } fetch_state_t;

   typedef enum logic [1:0] {
      PC_HOLD = 2'd0,
      PC_INC  = 2'd1,
      PC_LOAD = 2'd2
   } pc_sel_t;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [ILEN-1:0] instr;
      logic            valid;
   } ifid_t;

   localparam ifid_t IFID_FLUSH = '{pc: '0, instr: NOP_INSTR, valid: 1'b0};

   // Instructions are word aligned; drop the two low address bits.
   function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] addr);
      return {addr[XLEN-1:2], 2'b00};
   endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Fetch-stage bus bundle: hazard/branch control in, instruction memory port,
// and the IF/ID register plus status outputs.
//   master : control/memory/decode side (drives stall, branch, instruction)
//   slave  : fetch_stage itself
interface fetch_stage_if #(
   parameter int unsigned CNT_W = 32
);
   import riscv_pkg::*;

   logic             stall;
   logic             branch_taken;
   logic [XLEN-1:0]  branch_target;
   logic [XLEN-1:0]  inst_address;
   logic [ILEN-1:0]  instruction;
   logic [XLEN-1:0]  ifid_pc;
   logic [ILEN-1:0]  ifid_instruction;
   logic             ifid_valid;
   logic             halted;
   logic             misaligned_err;
   logic [CNT_W-1:0] fetch_count;

   modport master (
      output stall, branch_taken, branch_target, instruction,
      input  inst_address, ifid_pc, ifid_instruction, ifid_valid,
             halted, misaligned_err, fetch_count
   );

   modport slave (
      input  stall, branch_taken, branch_target, instruction,
      output inst_address, ifid_pc, ifid_instruction, ifid_valid,
             halted, misaligned_err, fetch_count
   );

endinterface

// File: rtl/fetch_stage_pc_reg.sv
// Program counter register with next-PC mux.
//   clk, reset_n : clock, async active-low reset (loads RESET_PC)
//   pc_sel_i     : hold / pc+4 / load target
//   target_i     : already word-aligned redirect address
//   pc_o         : current PC
module fetch_pc_reg
   import riscv_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC = 64'h0
) (
   input  logic            clk,
   input  logic            reset_n,
   input  pc_sel_t         pc_sel_i,
   input  logic [XLEN-1:0] target_i,
   output logic [XLEN-1:0] pc_o
);

   logic [XLEN-1:0] pc_q;
   logic [XLEN-1:0] pc_d;

   // Next-PC mux; pc+4 wraps modulo 2^64.
   always_comb begin
      pc_d = pc_q;
      unique case (pc_sel_i)
         PC_INC:  pc_d = pc_q + PC_STEP;
         PC_LOAD: pc_d = target_i;
         default: pc_d = pc_q;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) pc_q <= RESET_PC;
      else          pc_q <= pc_d;
   end

   assign pc_o = pc_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, presents it to instruction memory,
// captures the returned word into IF/ID, and handles stall, branch redirect
// and end-of-image halt.
//   clk, reset_n : clock, async active-low reset
//   fif (slave)  : stall/branch in, inst_address/instruction memory port,
//                  ifid_* register, halted, misaligned_err, fetch_count
module fetch_stage
   import riscv_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC   = 64'h0,
   parameter int unsigned     PROG_BYTES = 88,
   parameter int unsigned     CNT_W      = 32
) (
   input  logic          clk,
   input  logic          reset_n,
   fetch_stage_if.slave  fif
);

   localparam logic [XLEN-1:0] PROG_END = XLEN'(PROG_BYTES);

   fetch_state_t     state_q, state_d;
   ifid_t            ifid_q, ifid_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             err_q, err_d;
   pc_sel_t          pc_sel;
   logic [XLEN-1:0]  pc;
   logic [XLEN-1:0]  target_aligned;
   logic             pc_at_end;

   assign target_aligned = align_pc(fif.branch_target);
   assign pc_at_end      = (pc >= PROG_END);

   fetch_pc_reg #(
      .RESET_PC (RESET_PC)
   ) u_pc_reg (
      .clk      (clk),
      .reset_n  (reset_n),
      .pc_sel_i (pc_sel),
      .target_i (target_aligned),
      .pc_o     (pc)
   );

   // State register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state_q <= RUN;
      else          state_q <= state_d;
   end

   // Next state: redirect > stall > halt-hold > run.
   always_comb begin
      state_d = state_q;
      if (fif.branch_taken) begin
         state_d = (target_aligned >= PROG_END) ? HALT : RUN;
      end else if (!fif.stall && state_q == RUN && pc_at_end) begin
         state_d = HALT;
      end
   end

   // Datapath controls and IF/ID/counter/error next values, same priority.
   always_comb begin
      pc_sel = PC_HOLD;
      ifid_d = ifid_q;
      cnt_d  = cnt_q;
      err_d  = err_q;
      if (fif.branch_taken) begin
         pc_sel = PC_LOAD;
         ifid_d = IFID_FLUSH;
         if (fif.branch_target[1:0] != 2'b00) err_d = 1'b1;
      end else if (!fif.stall) begin
         if (state_q == HALT || pc_at_end) begin
            ifid_d = IFID_FLUSH;
         end else begin
            pc_sel = PC_INC;
            ifid_d = '{pc: pc, instr: fif.instruction, valid: 1'b1};
            if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ifid_q <= IFID_FLUSH;
         cnt_q  <= '0;
         err_q  <= 1'b0;
      end else begin
         ifid_q <= ifid_d;
         cnt_q  <= cnt_d;
         err_q  <= err_d;
      end
   end

   assign fif.inst_address     = pc;
   assign fif.ifid_pc          = ifid_q.pc;
   assign fif.ifid_instruction = ifid_q.instr;
   assign fif.ifid_valid       = ifid_q.valid;
   assign fif.halted           = (state_q == HALT);
   assign fif.misaligned_err   = err_q;
   assign fif.fetch_count      = cnt_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios on the sort-program
// image followed by randomized stall/redirect/reset traffic, all compared
// against a per-edge behavioural model of the fetch rules.
module tb_fetch_stage;
   import riscv_pkg::*;

   localparam int unsigned PROG_BYTES = 88;
   localparam int unsigned CNT_W      = 32;

   logic clk = 1'b0;
   logic reset_n;
   always #5 clk = ~clk;

   fetch_stage_if #(.CNT_W(CNT_W)) fif ();

   fetch_stage #(
      .RESET_PC   (64'h0),
      .PROG_BYTES (PROG_BYTES),
      .CNT_W      (CNT_W)
   ) u_dut (
      .clk     (clk),
      .reset_n (reset_n),
      .fif     (fif.slave)
   );

   // Program image; words at 0x00, 0x04, 0x10, 0x28, 0x4C are the known sort-program words.
   logic [31:0] rom [0:21];
   initial begin
      rom[0]  = 32'h0000_0913; rom[1]  = 32'h0000_0433; rom[2]  = 32'h0050_0493;
      rom[3]  = 32'h0694_5863; rom[4]  = 32'h0004_09b3; rom[5]  = 32'h0003_3a03;
      rom[6]  = 32'h0089_ba83; rom[7]  = 32'h014a_d663; rom[8]  = 32'h0159_b023;
      rom[9]  = 32'h0149_b423; rom[10] = 32'h0089_8993; rom[11] = 32'hfff4_8493;
      rom[12] = 32'hfe94_46e3; rom[13] = 32'h0014_0413; rom[14] = 32'hfc94_40e3;
      rom[15] = 32'h0000_0513; rom[16] = 32'h0000_0593; rom[17] = 32'h00b5_0533;
      rom[18] = 32'h0015_8593; rom[19] = 32'h0014_0413; rom[20] = 32'h0000_0073;
      rom[21] = 32'h0000_006f;
   end

   function automatic logic [31:0] imem(input logic [63:0] a);
      if (a < 64'(PROG_BYTES)) return rom[a[6:2]];
      return a[31:0] ^ 32'hA5A5_5A5A;
   endfunction

   always_comb fif.instruction = imem(fif.inst_address);

   // Reference model state.
   logic [63:0]      m_pc, m_ifid_pc;
   logic [31:0]      m_ifid_instr;
   logic             m_valid, m_halt, m_err;
   logic [CNT_W-1:0] m_cnt;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_pc = 64'h0; m_ifid_pc = 64'h0; m_ifid_instr = NOP_INSTR;
      m_valid = 1'b0; m_halt = 1'b0; m_err = 1'b0; m_cnt = '0;
   endtask

   task automatic model_flush();
      m_ifid_pc = 64'h0; m_ifid_instr = NOP_INSTR; m_valid = 1'b0;
   endtask

   // One clock edge of the fetch rules, in priority order.
   task automatic model_edge(input logic s, input logic b, input logic [63:0] t);
      if (b) begin
         m_pc = t & ~64'h3;
         model_flush();
         if (t % 4 != 0) m_err = 1'b1;
         m_halt = (m_pc >= 64'(PROG_BYTES));
      end else if (s) begin
         // everything holds
      end else if (m_halt) begin
         model_flush();
      end else if (m_pc >= 64'(PROG_BYTES)) begin
         m_halt = 1'b1;
         model_flush();
      end else begin
         m_ifid_pc = m_pc; m_ifid_instr = imem(m_pc); m_valid = 1'b1;
         m_pc = m_pc + 64'd4;
         if (m_cnt != {CNT_W{1'b1}}) m_cnt = m_cnt + 1'b1;
      end
   endtask

   task automatic compare_model();
      check_eq("inst_address", fif.inst_address, m_pc);
      check_eq("ifid_pc", fif.ifid_pc, m_ifid_pc);
      check_eq("ifid_instruction", 64'(fif.ifid_instruction), 64'(m_ifid_instr));
      check_eq("ifid_valid", 64'(fif.ifid_valid), 64'(m_valid));
      check_eq("halted", 64'(fif.halted), 64'(m_halt));
      check_eq("misaligned_err", 64'(fif.misaligned_err), 64'(m_err));
      check_eq("fetch_count", 64'(fif.fetch_count), 64'(m_cnt));
   endtask

   // Drive inputs at the falling edge, step model, check just after the rising edge.
   task automatic cycle(input logic s, input logic b, input logic [63:0] t);
      fif.stall = s; fif.branch_taken = b; fif.branch_target = t;
      model_edge(s, b, t);
      @(posedge clk); #1;
      compare_model();
      @(negedge clk);
   endtask

   task automatic apply_reset(input int n);
      fif.stall = 1'b0; fif.branch_taken = 1'b0; fif.branch_target = '0;
      reset_n = 1'b0;
      model_reset();
      repeat (n) @(negedge clk);
      compare_model();
      reset_n = 1'b1;
   endtask

   initial begin
      int budget;
      logic        s, b;
      logic [63:0] t;

      reset_n = 1'b1;
      fif.stall = 1'b0; fif.branch_taken = 1'b0; fif.branch_target = '0;
      #1;

      // 1. reset and first fetch
      apply_reset(3);
      check_eq("t1_addr_after_reset", fif.inst_address, 64'h0);
      check_eq("t1_nop_after_reset", 64'(fif.ifid_instruction), 64'h13);
      cycle(1'b0, 1'b0, '0);
      check_eq("t1_instr", 64'(fif.ifid_instruction), 64'h0000_0913);
      check_eq("t1_pc", fif.ifid_pc, 64'h0);
      check_eq("t1_valid", 64'(fif.ifid_valid), 64'h1);
      check_eq("t1_count", 64'(fif.fetch_count), 64'h1);

      // 2. stall at pc=8
      cycle(1'b0, 1'b0, '0);
      check_eq("t2_pc_pre", fif.inst_address, 64'h8);
      cycle(1'b1, 1'b0, '0);
      cycle(1'b1, 1'b0, '0);
      check_eq("t2_pc_hold", fif.inst_address, 64'h8);
      check_eq("t2_ifid_pc", fif.ifid_pc, 64'h4);
      check_eq("t2_instr", 64'(fif.ifid_instruction), 64'h0000_0433);
      check_eq("t2_count", 64'(fif.fetch_count), 64'h2);

      // 3. redirect from 0x3C to 0x28
      budget = 40;
      while (fif.inst_address != 64'h3C && budget > 0) begin
         cycle(1'b0, 1'b0, '0);
         budget--;
      end
      check_eq("t3_reach_3c", fif.inst_address, 64'h3C);
      cycle(1'b0, 1'b1, 64'h28);
      check_eq("t3_flush_valid", 64'(fif.ifid_valid), 64'h0);
      check_eq("t3_flush_nop", 64'(fif.ifid_instruction), 64'h13);
      check_eq("t3_pc", fif.inst_address, 64'h28);
      cycle(1'b0, 1'b0, '0);
      check_eq("t3_instr", 64'(fif.ifid_instruction), 64'h0089_8993);
      check_eq("t3_ifid_pc", fif.ifid_pc, 64'h28);

      // 4. redirect beats stall
      cycle(1'b1, 1'b1, 64'h10);
      check_eq("t4_pc", fif.inst_address, 64'h10);
      check_eq("t4_flush", 64'(fif.ifid_valid), 64'h0);
      cycle(1'b0, 1'b0, '0);
      check_eq("t4_instr", 64'(fif.ifid_instruction), 64'h0004_09b3);

      // 5. free-run from reset to halt, then resume by redirect
      apply_reset(1);
      budget = 60;
      while (!fif.halted && budget > 0) begin
         cycle(1'b0, 1'b0, '0);
         budget--;
      end
      check_eq("t5_halted", 64'(fif.halted), 64'h1);
      check_eq("t5_count", 64'(fif.fetch_count), 64'd22);
      check_eq("t5_pc", fif.inst_address, 64'd88);
      check_eq("t5_valid", 64'(fif.ifid_valid), 64'h0);
      cycle(1'b0, 1'b0, '0);
      cycle(1'b0, 1'b0, '0);
      check_eq("t5_pc_stays", fif.inst_address, 64'd88);
      check_eq("t5_count_stays", 64'(fif.fetch_count), 64'd22);
      cycle(1'b0, 1'b1, 64'h4C);
      check_eq("t5_resume_run", 64'(fif.halted), 64'h0);
      cycle(1'b0, 1'b0, '0);
      check_eq("t5_resume_instr", 64'(fif.ifid_instruction), 64'h0014_0413);

      // 6. misaligned redirect, sticky flag, async reset mid-stall
      cycle(1'b0, 1'b1, 64'h2A);
      check_eq("t6_pc", fif.inst_address, 64'h28);
      check_eq("t6_err", 64'(fif.misaligned_err), 64'h1);
      cycle(1'b0, 1'b0, '0);
      cycle(1'b0, 1'b1, 64'h30);
      check_eq("t6_err_sticky", 64'(fif.misaligned_err), 64'h1);
      fif.stall = 1'b1;
      #2;
      reset_n = 1'b0;
      model_reset();
      #1;
      compare_model();
      check_eq("t6_async_valid", 64'(fif.ifid_valid), 64'h0);
      check_eq("t6_async_err", 64'(fif.misaligned_err), 64'h0);
      @(negedge clk);
      reset_n = 1'b1;
      fif.stall = 1'b0;

      // Randomized traffic.
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 199) == 0) begin
            apply_reset(1);
         end else begin
            s = ($urandom_range(0, 3) == 0);
            b = ($urandom_range(0, 11) == 0);
            if ($urandom_range(0, 19) == 0)
               t = {$urandom(), $urandom()};
            else
               t = 64'($urandom_range(0, 27) * 4 + $urandom_range(0, 3));
            cycle(s, b, t);
         end
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
